riscv_v_rf_wb_seq: RTL

// Vector writeback sequencer: the write-side initiator of the vector register file.
// - Accepts result beats from vector execute/load units over a valid/ready handshake.
// - Turns SEW, vstart, vl and the v0 mask into a per-byte write-enable.
// - Buffers beats in a small in-order FIFO and drives the RF write port (wr_addr/data_in/wr_en).
// - Exposes a pending-write query so decode can stall reads of registers with writes still queued.

---
 rtl/riscv_v_rf_wb_seq_if.sv | 18 +
 rtl/riscv_v_rf_wb_seq.sv | 72 +++++++
 2 files changed

// File: rtl/riscv_v_rf_wb_seq_if.sv
// riscv_v_rf_wb_seq_if: result-beat valid/ready bus from vector execute/load units
interface riscv_v_rf_wb_seq_if #(
  parameter int DATA_BYTES = 16,
  parameter int ADDR_W     = 5
);
  localparam int VL_W = $clog2(DATA_BYTES) + 1;
  logic                    valid;
  logic                    ready;
  logic [ADDR_W-1:0]       vd;
  logic [DATA_BYTES*8-1:0] data;
  logic [1:0]              sew;
  logic [VL_W-1:0]         vl;
  logic [VL_W-1:0]         vstart;
  logic                    vm;
  logic [DATA_BYTES-1:0]   mask;
  modport master (output valid, vd, data, sew, vl, vstart, vm, mask, input ready);
  modport slave  (input valid, vd, data, sew, vl, vstart, vm, mask, output ready);
endinterface

// File: rtl/riscv_v_rf_wb_seq.sv
// riscv_v_rf_wb_seq: queues vector result beats and drives the RF byte-enabled write port
module riscv_v_rf_wb_seq #(
  parameter int DATA_BYTES = 16,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  riscv_v_rf_wb_seq_if.slave              in_if,
  input  logic                            rf_wr_stall,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [DATA_BYTES*8-1:0]         data_in,
  output logic [DATA_BYTES-1:0]           wr_en,
  input  logic [ADDR_W-1:0]               query_addr,
  output logic                            query_hit,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0]       vd_q   [FIFO_DEPTH];
  logic [DATA_BYTES*8-1:0] data_q [FIFO_DEPTH];
  logic [DATA_BYTES-1:0]   be_q   [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    push, pop;
  logic [DATA_BYTES-1:0]   be;
  int                      ne, vl_eff;
  assign in_if.ready = rst_n && (count != CW'(FIFO_DEPTH));
  assign push        = in_if.valid && in_if.ready;
  assign pop         = (count != '0) && !rf_wr_stall;
  assign wr_addr     = vd_q[rd_ptr];
  assign data_in     = data_q[rd_ptr];
  assign wr_en       = pop ? be_q[rd_ptr] : '0;
  assign fifo_count  = count;
  // byte enable: byte b belongs to element b>>sew, active inside [vstart, min(vl,NE)) and unmasked
  always_comb begin
    be     = '0;
    ne     = DATA_BYTES >> in_if.sew;
    vl_eff = int'(in_if.vl) < ne ? int'(in_if.vl) : ne;
    for (int b = 0; b < DATA_BYTES; b++)
      be[b] = (b >> in_if.sew) >= int'(in_if.vstart) && (b >> in_if.sew) < vl_eff &&
              (in_if.vm || in_if.mask[b >> in_if.sew]);
  end
  // in-order circular FIFO; async reset drops every queued beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        vd_q[i]   <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        vd_q[wr_ptr]   <= in_if.vd;
        data_q[wr_ptr] <= in_if.data;
        be_q[wr_ptr]   <= be;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // pending-write query over occupied entries, walked from the head
  always_comb begin
    query_hit = 1'b0;
    for (int k = 0; k < FIFO_DEPTH; k++)
      query_hit = query_hit || (k < int'(count) && vd_q[rd_ptr + PW'(k)] == query_addr);
  end
endmodule
